// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared widths, divider FSM states and handshake constants.
package ex_div_pkg;
  localparam int REG_BUS = 32;
  localparam logic [5:0] DIV_ITERS = 6'd32;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP = 1'b0;
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;
endpackage

// File: rtl/ex_div.sv
// ex_div: 32-bit radix-2 restoring divider for the EX stage, signed and unsigned.
// Defining DIV_ZERO_FLAG_EN adds div_zero_o, flagging results produced by a zero divisor.
module ex_div
  import ex_div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_div_i,
  input  logic [REG_BUS-1:0]   opdata1_i,
  input  logic [REG_BUS-1:0]   opdata2_i,
  input  logic                 annul_i,
  output logic [2*REG_BUS-1:0] result_o,
  output logic                 ready_o,
  output logic                 stall_req_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                 div_zero_o
`endif
);
  div_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [REG_BUS-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic sgn1_q, sgn1_d, sgn2_q, sgn2_d;
  logic [2*REG_BUS-1:0] result_q, result_d;
  logic ready_q, ready_d;
  logic zero_q, zero_d;
  logic [REG_BUS:0] partial, diff;
  logic [REG_BUS-1:0] quo_fix, rem_fix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      sgn1_q   <= sgn1_d;
      sgn2_q   <= sgn2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      zero_q   <= zero_d;
    end
  end

  // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    sgn1_d   = sgn1_q;
    sgn2_d   = sgn2_q;
    result_d = result_q;
    ready_d  = ready_q;
    zero_d   = zero_q;
    partial  = {rem_q, quo_q[REG_BUS-1]};
    diff     = partial - {1'b0, dvsr_q};
    quo_fix  = (sgn1_q ^ sgn2_q) ? -quo_q : quo_q;
    rem_fix  = sgn1_q ? -rem_q : rem_q;
    case (state_q)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d = DIV_ON;
            cnt_d   = '0;
            rem_d   = '0;
            sgn1_d  = signed_div_i & opdata1_i[REG_BUS-1];
            sgn2_d  = signed_div_i & opdata2_i[REG_BUS-1];
            quo_d   = sgn1_d ? -opdata1_i : opdata1_i;
            dvsr_d  = sgn2_d ? -opdata2_i : opdata2_i;
          end
        end
      end
      DIV_BYZERO: begin
        state_d  = annul_i ? DIV_FREE : DIV_END;
        result_d = '0;
        ready_d  = annul_i ? DIV_RESULT_NOT_READY : DIV_RESULT_READY;
        zero_d   = !annul_i;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else if (cnt_q != DIV_ITERS) begin
          quo_d = {quo_q[REG_BUS-2:0], ~diff[REG_BUS]};
          rem_d = diff[REG_BUS] ? partial[REG_BUS-1:0] : diff[REG_BUS-1:0];
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = DIV_END;
          result_d = {rem_fix, quo_fix};
          ready_d  = DIV_RESULT_READY;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
          zero_d   = 1'b0;
        end
      end
    endcase
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign stall_req_o = start_i && !ready_q && !annul_i;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero_o  = zero_q & ready_q;
`else
  logic unused_zero;
  assign unused_zero = zero_q;
`endif
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: randomized scoreboard bench for ex_div against a plain-arithmetic divide model.
module tb_ex_div;
  logic        clk, rst, start_i, signed_div_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, stall_req_o;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero_o;
`endif
  int total = 0, passed = 0;
  logic [64:0] exp_q[$];
  logic        rdy_prev = 1'b0;

  ex_div dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stall_req_o(stall_req_o)
`ifdef DIV_ZERO_FLAG_EN
    , .div_zero_o(div_zero_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Truncating division, remainder follows the dividend; 64-bit math makes MIN/-1 wrap naturally.
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, qq, rr;
    if (b == 0) return {1'b1, 64'h0};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    qq = sa / sb;
    rr = sa % sb;
    return {1'b0, rr[31:0], qq[31:0]};
  endfunction

  always @(negedge clk) begin
    if (ready_o && !rdy_prev) begin
      if (exp_q.size() == 0) chk("unexpected_ready", {63'h0, ready_o}, 64'h0);
      else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        chk("result", result_o, e[63:0]);
`ifdef DIV_ZERO_FLAG_EN
        chk("div_zero", {63'h0, div_zero_o}, {63'h0, e[64]});
`endif
      end
    end
    rdy_prev <= ready_o;
  end

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int hold, input bit drop);
    logic [64:0] e;
    int lat, stall_bad;
    e = model(a, b, sgn);
    exp_q.push_back(e);
    @(negedge clk);
    start_i = 1'b1; signed_div_i = sgn; opdata1_i = a; opdata2_i = b;
    #1 chk("stall_at_issue", {63'h0, stall_req_o}, 64'h1);
    lat = 0; stall_bad = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin opdata1_i = $urandom; opdata2_i = $urandom; end
      if (!ready_o && !stall_req_o) stall_bad++;
    end while (!ready_o && lat < 60);
    chk("latency", 64'(lat), (b == 0) ? 64'd2 : 64'd34);
    chk("stall_while_busy", 64'(stall_bad), 64'd0);
    chk("stall_in_end", {63'h0, stall_req_o}, 64'h0);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_result", result_o, e[63:0]);
      chk("hold_ready", {63'h0, ready_o}, 64'h1);
    end
    if (drop) begin
      @(negedge clk);
      start_i = 1'b0; opdata1_i = $urandom; opdata2_i = $urandom;
      @(posedge clk); #1;
      chk("drop_ready", {63'h0, ready_o}, 64'h0);
      chk("drop_result", result_o, 64'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_seen;
    rst = 1'b1; start_i = 1'b0; signed_div_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #1 rst = 1'b0;
    #1;
    chk("reset_ready", {63'h0, ready_o}, 64'h0);
    chk("reset_result", result_o, 64'h0);
    chk("reset_stall", {63'h0, stall_req_o}, 64'h0);
    @(negedge clk) rst = 1'b1;

    do_div(32'd100, 32'd7, 1'b0, 0, 1);
    do_div(-32'sd7, 32'd2, 1'b1, 0, 1);
    do_div(32'd7, -32'sd2, 1'b1, 0, 1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1);
    do_div(32'd5, 32'd0, 1'b0, 1, 1);
    do_div(32'h8000_0000, 32'd0, 1'b1, 0, 1);
    do_div(32'd123456, 32'd789, 1'b0, 5, 1);
    do_div(32'd3, 32'd10, 1'b1, 0, 1);

    // flush mid-division: no result may appear, then a fresh divide completes
    @(negedge clk);
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    repeat (11) @(posedge clk);
    @(negedge clk) annul_i = 1'b1;
    #1 chk("annul_stall", {63'h0, stall_req_o}, 64'h0);
    @(negedge clk) begin annul_i = 1'b0; start_i = 1'b0; end
    rdy_seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) rdy_seen++; end
    chk("annul_no_ready", 64'(rdy_seen), 64'd0);
    do_div(32'd9, 32'd3, 1'b0, 0, 1);

    // asynchronous reset mid-division
    @(negedge clk);
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'd3;
    repeat (21) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_mid_ready", {63'h0, ready_o}, 64'h0);
    chk("rst_mid_result", result_o, 64'h0);
    start_i = 1'b0;
    @(negedge clk) rst = 1'b1;
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1);

    // asynchronous reset while a result is being held
    do_div(32'd20, 32'd6, 1'b0, 2, 0);
    #2 rst = 1'b0;
    #1 chk("rst_end_result", result_o, 64'h0);
    chk("rst_end_ready", {63'h0, ready_o}, 64'h0);
    @(negedge clk) start_i = 1'b0;
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 1) ? 32'($urandom) : 32'($urandom_range(1, 20)));
      do_div(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
